// File: rtl/sha_msg_padder.sv
// SHA-256 style message padder: packs a byte stream into 512-bit blocks,
// appends 0x80, zero fill and the big-endian bit length of the message.
module sha_msg_padder #(
    parameter int MSG_SIZ = 512,
    parameter int LEN_W   = 64
) (
    input  logic               usr_clk,
    input  logic               usr_reset,
    input  logic [7:0]         i_byte,
    input  logic               i_byte_valid,
    input  logic               i_last,
    output logic               o_byte_ready,
    output logic [MSG_SIZ-1:0] o_blk,
    output logic               o_blk_valid,
    output logic               o_blk_last,
    input  logic               i_blk_ready,
    output logic               o_busy
);

    localparam int CNT_W = LEN_W - 3;
    localparam int LEN_B = LEN_W / 8;
    localparam int BLK_B = MSG_SIZ / 8;

    typedef enum logic [2:0] {IDLE, LOAD, PAD, LEN, SEND} state_t;

    state_t                    state_q, state_d;
    state_t                    pend_q, pend_d;
    logic [BLK_B-1:0][7:0]     buf_q, buf_d;
    logic [5:0]                idx_q, idx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      snap;
    logic                      last_d;
    logic                      xfer;

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        buf_d        = buf_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        snap         = 1'b0;
        last_d       = 1'b0;
        xfer         = 1'b0;
        o_byte_ready = 1'b0;

        // Byte 0 sits in the top byte lane, so lane index is 63 - idx (= ~idx).
        case (state_q)
            IDLE, LOAD: begin
                o_byte_ready = 1'b1;
                if (i_byte_valid) begin
                    buf_d[~idx_q] = i_byte;
                    idx_d         = idx_q + 6'd1;
                    cnt_d         = cnt_q + CNT_W'(1);
                end
                if (i_byte_valid && idx_q == 6'd63) begin
                    snap    = 1'b1;
                    pend_d  = i_last ? PAD : LOAD;
                    state_d = SEND;
                end else if (i_last) begin
                    state_d = PAD;
                end else if (i_byte_valid) begin
                    state_d = LOAD;
                end
            end
            PAD: begin
                buf_d[~idx_q] = 8'h80;
                idx_d         = idx_q + 6'd1;
                // No room left for the length field: flush this block first.
                if (idx_q >= 6'd56) begin
                    snap    = 1'b1;
                    pend_d  = LEN;
                    state_d = SEND;
                end else begin
                    state_d = LEN;
                end
            end
            LEN: begin
                buf_d[LEN_B-1:0] = {cnt_q, 3'b000};
                snap             = 1'b1;
                last_d           = 1'b1;
                pend_d           = IDLE;
                state_d          = SEND;
                idx_d            = '0;
                cnt_d            = '0;
            end
            SEND: begin
                if (i_blk_ready) begin
                    xfer    = 1'b1;
                    state_d = pend_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge usr_clk or posedge usr_reset) begin
        if (usr_reset) begin
            state_q     <= IDLE;
            pend_q      <= IDLE;
            buf_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            o_blk       <= '0;
            o_blk_valid <= 1'b0;
            o_blk_last  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            if (snap) begin
                o_blk       <= buf_d;
                o_blk_last  <= last_d;
                o_blk_valid <= 1'b1;
                buf_q       <= '0;
            end else begin
                buf_q <= buf_d;
                if (xfer) begin
                    o_blk_valid <= 1'b0;
                end
            end
        end
    end

    assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_sha_msg_padder.sv
// Randomized bench for sha_msg_padder; expected blocks come from a
// byte-queue padding model of the message.
module tb_sha_msg_padder;

    typedef logic [7:0] byte_q_t[$];

    logic         usr_clk = 1'b0;
    logic         usr_reset;
    logic [7:0]   i_byte;
    logic         i_byte_valid;
    logic         i_last;
    logic         o_byte_ready;
    logic [511:0] o_blk;
    logic         o_blk_valid;
    logic         o_blk_last;
    logic         i_blk_ready;
    logic         o_busy;

    sha_msg_padder #(.MSG_SIZ(512), .LEN_W(64)) dut (
        .usr_clk     (usr_clk),
        .usr_reset   (usr_reset),
        .i_byte      (i_byte),
        .i_byte_valid(i_byte_valid),
        .i_last      (i_last),
        .o_byte_ready(o_byte_ready),
        .o_blk       (o_blk),
        .o_blk_valid (o_blk_valid),
        .o_blk_last  (o_blk_last),
        .i_blk_ready (i_blk_ready),
        .o_busy      (o_busy)
    );

    always #5 usr_clk = ~usr_clk;

    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    int           rdy_pct = 100;
    logic [511:0] exp_blk_q[$];
    bit           exp_last_q[$];
    bit           hold_pending = 0;
    bit           prev_xfer = 0;
    bit           prev_valid = 0;
    logic [511:0] held_blk;
    logic         held_last;
    int           rise_cyc = -1;
    int           end_cyc = -1;

    // Reference: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
    function automatic void build_expected(input byte_q_t msg);
        byte_q_t      pad;
        logic [63:0]  len;
        logic [511:0] blk;
        int           nblk;
        pad = msg;
        pad.push_back(8'h80);
        while (pad.size() % 64 != 56) pad.push_back(8'h00);
        len = 64'(msg.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) pad.push_back(len[8*k +: 8]);
        nblk = pad.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = pad[64*b + j];
            exp_blk_q.push_back(blk);
            exp_last_q.push_back(b == nblk - 1);
        end
    endfunction

    // One clock: randomize downstream ready, then check any block it transfers.
    task automatic cycle();
        logic [511:0] e;
        bit           el;
        @(negedge usr_clk);
        cyc++;
        i_blk_ready = ($urandom_range(99) < rdy_pct);
        if (prev_xfer) begin
            vectors++;
            if (o_blk_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL valid_after_xfer got=%b want=0", o_blk_valid);
            end
        end
        if (hold_pending) begin
            vectors++;
            if (o_blk_valid !== 1'b1 || o_blk !== held_blk || o_blk_last !== held_last) begin
                miscompares++;
                $display("FAIL hold_stable got valid=%b last=%b blk=%h want valid=1 last=%b blk=%h",
                         o_blk_valid, o_blk_last, o_blk, held_last, held_blk);
            end
        end
        if (o_blk_valid === 1'b1 && !prev_valid) rise_cyc = cyc;
        prev_valid   = (o_blk_valid === 1'b1);
        prev_xfer    = 0;
        hold_pending = 0;
        if (o_blk_valid === 1'b1) begin
            if (i_blk_ready) begin
                prev_xfer = 1;
                vectors++;
                if (exp_blk_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_blk got=%h want=none", o_blk);
                end else begin
                    e  = exp_blk_q.pop_front();
                    el = exp_last_q.pop_front();
                    if (o_blk !== e || o_blk_last !== el) begin
                        miscompares++;
                        $display("FAIL blk got last=%b %h want last=%b %h", o_blk_last, o_blk, el, e);
                    end
                end
            end else begin
                hold_pending = 1;
                held_blk     = o_blk;
                held_last    = o_blk_last;
            end
        end
    endtask

    task automatic drive_msg(input byte_q_t msg, input bit last_sep);
        int i = 0;
        int budget = 0;
        bit done = 0;
        build_expected(msg);
        while (!done && budget < 5000) begin
            cycle();
            budget++;
            if (i < msg.size()) begin
                i_byte_valid = ($urandom_range(3) != 0);
                i_byte       = msg[i];
                i_last       = i_byte_valid && (i == msg.size() - 1) && !last_sep;
            end else begin
                i_byte_valid = 1'b0;
                i_byte       = 8'($urandom);
                i_last       = 1'b1;
            end
            if (o_byte_ready === 1'b1) begin
                if (i_byte_valid) i++;
                if (i_last) begin
                    done    = 1;
                    end_cyc = cyc;
                end
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL end_accept_timeout got=%0d bytes want=%0d", i, msg.size());
        end
    endtask

    task automatic drain();
        int budget = 0;
        cycle();
        i_byte_valid = 1'b0;
        i_last       = 1'b0;
        while (exp_blk_q.size() > 0 && budget < 3000) begin
            cycle();
            budget++;
        end
        if (exp_blk_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout got=%0d blocks left want=0", exp_blk_q.size());
            exp_blk_q.delete();
            exp_last_q.delete();
        end
        cycle();
        cycle();
        vectors++;
        if (o_busy !== 1'b0 || o_blk_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_msg got busy=%b valid=%b want 0 0", o_busy, o_blk_valid);
        end
    endtask

    task automatic do_reset();
        @(negedge usr_clk);
        usr_reset    = 1'b1;
        i_byte_valid = 1'b0;
        i_last       = 1'b0;
        #1;
        vectors++;
        if (o_blk !== '0 || o_blk_valid !== 1'b0 || o_blk_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_blk got valid=%b last=%b blk=%h want all 0", o_blk_valid, o_blk_last, o_blk);
        end
        vectors++;
        if (o_busy !== 1'b0 || o_byte_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_status got busy=%b ready=%b want 0 1", o_busy, o_byte_ready);
        end
        @(negedge usr_clk);
        usr_reset    = 1'b0;
        hold_pending = 0;
        prev_xfer    = 0;
        prev_valid   = 0;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_abc();
        byte_q_t msg;
        msg = '{8'h61, 8'h62, 8'h63};
        rdy_pct = 100;
        drive_msg(msg, 0);
        drain();
        vectors++;
        if (rise_cyc - end_cyc != 3) begin
            miscompares++;
            $display("FAIL abc_latency got=%0d want=3", rise_cyc - end_cyc);
        end
    endtask

    task automatic test_boundaries();
        int lens[8] = '{55, 56, 57, 63, 64, 119, 120, 128};
        byte_q_t msg;
        rdy_pct = 70;
        foreach (lens[n]) begin
            for (int sep = 0; sep < 2; sep++) begin
                msg.delete();
                for (int k = 0; k < lens[n]; k++)
                    msg.push_back((lens[n] == 55) ? 8'h00 : 8'($urandom));
                drive_msg(msg, sep[0]);
                drain();
            end
        end
    endtask

    task automatic test_empty_stall();
        byte_q_t msg;
        rdy_pct = 100;
        drive_msg(msg, 0);
        rdy_pct = 0;
        for (int k = 0; k < 13; k++) begin
            cycle();
            i_byte_valid = 1'b0;
            i_last       = 1'b0;
        end
        vectors++;
        if (o_blk_valid !== 1'b1 || o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL empty_stall got valid=%b busy=%b want 1 1", o_blk_valid, o_busy);
        end
        rdy_pct = 100;
        drain();
    endtask

    task automatic test_reset_abort();
        int sent = 0;
        int budget = 0;
        rdy_pct = 100;
        while (sent < 20 && budget < 200) begin
            cycle();
            budget++;
            i_byte_valid = 1'b1;
            i_byte       = 8'($urandom);
            i_last       = 1'b0;
            if (o_byte_ready === 1'b1) sent++;
        end
        do_reset();
        cycle();
        test_abc();
    endtask

    task automatic test_random();
        byte_q_t msg;
        for (int m = 0; m < 25; m++) begin
            rdy_pct = $urandom_range(100, 20);
            msg.delete();
            for (int k = 0; k < int'($urandom_range(200)); k++) msg.push_back(8'($urandom));
            drive_msg(msg, $urandom_range(1));
            drain();
        end
    endtask

    initial begin
        usr_reset    = 1'b1;
        i_byte       = 8'h00;
        i_byte_valid = 1'b0;
        i_last       = 1'b0;
        i_blk_ready  = 1'b0;
        test_reset();
        test_abc();
        test_boundaries();
        test_empty_stall();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
